laser_pulse_monitor: RTL and testbench
======================================

LASER_PULSE_MONITOR -- requirements
Module: laser_pulse_monitor

Interface
REQ-001 Parameter PULSE_CYCLES, default 3: required high width of a valid laser pulse, in clk cycles.
REQ-002 Parameter MAX_LEN, default 15: width at which a high level is declared stuck; MAX_LEN SHALL exceed PULSE_CYCLES.
REQ-003 Parameter CNT_W, default 8: width of the event counters.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 x  input  1  laser enable under observation, synchronous to clk; no synchronizer.
REQ-007 done  output  1  one-cycle strobe: a pulse ended normally.
REQ-008 pulse_len  output  4  width of the last completed pulse, held until the next done.
REQ-009 ok  output  1  pulse_len == PULSE_CYCLES, valid with done and held with pulse_len.
REQ-010 stuck  output  1  high while x has been high for MAX_LEN or more cycles.
REQ-011 good_cnt  output  CNT_W  count of pulses with ok=1.
REQ-012 bad_cnt  output  CNT_W  count of pulses with ok=0, plus stuck events.

Function
REQ-013 The FSM SHALL have the states IDLE, HIGH and STUCK, and all outputs SHALL be registered (Moore-style).
REQ-014 IDLE, x=1 sampled: go to HIGH and load len=1; IDLE, x=0: stay.
REQ-015 HIGH, x=1, len<MAX_LEN-1: stay and set len=len+1.
REQ-016 HIGH, x=1, len=MAX_LEN-1: go to STUCK; at that edge set stuck<=1 and bad_cnt+1; done stays 0.
REQ-017 HIGH, x=0: go to IDLE; at that edge set done<=1, pulse_len<=len, ok<=(len==PULSE_CYCLES), and increment good_cnt if ok, else bad_cnt.
REQ-018 Latency: done is high in the first cycle after the first low sample of x.
REQ-019 STUCK, x=1: stay with stuck held at 1 and no further count.
REQ-020 STUCK, x=0: go to IDLE and clear stuck; no done, and pulse_len/ok are unchanged.
REQ-021 Back-to-back pulse: in HIGH with x=0, the next x=1 sampled one cycle later (in IDLE) SHALL start a new pulse with no lost cycle.
REQ-022 done SHALL be 0 in every cycle except the one following REQ-017.
REQ-023 good_cnt and bad_cnt SHALL wrap modulo 2^CNT_W without saturation.
REQ-024 The len counter SHALL never exceed MAX_LEN-1, so 4 bits are sufficient for MAX_LEN<=16.
REQ-025 Illegal state encoding: go to IDLE on the next edge.

Reset
REQ-026 On rst assertion, immediately: state=IDLE, len=0, done=0, pulse_len=0, ok=0, stuck=0, good_cnt=0, bad_cnt=0.
REQ-027 Reset mid-pulse SHALL discard the pulse; after release with x still high, the next sample starts a new pulse from len=1.

Structure
REQ-028 Package laser_pkg SHALL hold the state encodings (IDLE=2'b00, HIGH=2'b01, STUCK=2'b10) and the default PULSE_CYCLES/MAX_LEN constants, shared with the laser timer FSMs.
REQ-029 Sub-module laser_evt_counter (CNT_W-bit wrapping incrementer with inc enable and async reset) SHALL be instantiated twice, for good_cnt and bad_cnt.

Verification
REQ-030 x high for 3 cycles, then low -> exactly one done cycle, pulse_len=3, ok=1, good_cnt=1, bad_cnt=0.
REQ-031 x high for 2 cycles, then 1 low cycle, then high for 4 cycles -> two done strobes: (2, ok=0) then (4, ok=0); bad_cnt=2, good_cnt=0.
REQ-032 x high for 20 cycles -> stuck=1 from the cycle after the 15th high sample; bad_cnt=1; no done; stuck=0 one cycle after x falls.
REQ-033 rst pulsed on the 2nd high cycle of a 3-cycle pulse -> all outputs 0, no done, counters remain 0.
REQ-034 256 valid 3-cycle pulses -> good_cnt wraps to 0; with one extra pulse, good_cnt=1.
REQ-035 Drive x from the mealy laser timer with b pulsed for 1 cycle -> done with pulse_len=3, ok=1.

Source files
------------

// File: rtl/laser_pkg.sv
// Shared encodings and defaults for the laser pulse monitor and laser timer FSMs.
package laser_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_HIGH  = 2'b01;
    localparam logic [1:0] ST_STUCK = 2'b10;

    localparam int unsigned DEF_PULSE_CYCLES = 3;
    localparam int unsigned DEF_MAX_LEN      = 15;
    localparam int unsigned LEN_W            = 4;

    function automatic logic [LEN_W-1:0] to_len(input int unsigned n);
        return LEN_W'(n);
    endfunction

endpackage

// File: rtl/laser_evt_counter.sv
// Wrapping event counter with increment enable.
module laser_evt_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/laser_pulse_monitor.sv
// Measures laser enable pulse widths, flags stuck-high levels and counts
// good and bad pulses.
module laser_pulse_monitor
    import laser_pkg::*;
#(
    parameter int unsigned PULSE_CYCLES = DEF_PULSE_CYCLES,
    parameter int unsigned MAX_LEN      = DEF_MAX_LEN,
    parameter int unsigned CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    output logic             done,
    output logic [3:0]       pulse_len,
    output logic             ok,
    output logic             stuck,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] bad_cnt
);

    localparam logic [LEN_W-1:0] LEN_LAST = to_len(MAX_LEN - 1);
    localparam logic [LEN_W-1:0] LEN_OK   = to_len(PULSE_CYCLES);

    logic [1:0]       state;
    logic [LEN_W-1:0] len;
    logic             pulse_end;
    logic             pulse_ok;
    logic             goes_stuck;
    logic             inc_good;
    logic             inc_bad;

    // Counter enables mirror the state-update decisions so they land on the same edge.
    always_comb begin
        pulse_end  = (state == ST_HIGH) && !x;
        pulse_ok   = (len == LEN_OK);
        goes_stuck = (state == ST_HIGH) && x && (len == LEN_LAST);
        inc_good   = pulse_end && pulse_ok;
        inc_bad    = (pulse_end && !pulse_ok) || goes_stuck;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            len       <= '0;
            done      <= 1'b0;
            pulse_len <= '0;
            ok        <= 1'b0;
            stuck     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (x) begin
                        state <= ST_HIGH;
                        len   <= to_len(1);
                    end
                end
                ST_HIGH: begin
                    if (!x) begin
                        state     <= ST_IDLE;
                        done      <= 1'b1;
                        pulse_len <= len;
                        ok        <= pulse_ok;
                    end else if (len == LEN_LAST) begin
                        state <= ST_STUCK;
                        stuck <= 1'b1;
                    end else begin
                        len <= len + to_len(1);
                    end
                end
                ST_STUCK: begin
                    if (!x) begin
                        state <= ST_IDLE;
                        stuck <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    laser_evt_counter #(.CNT_W(CNT_W)) u_good_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc_good),
        .count (good_cnt)
    );

    laser_evt_counter #(.CNT_W(CNT_W)) u_bad_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc_bad),
        .count (bad_cnt)
    );

endmodule

// File: tb/tb_laser_pulse_monitor.sv
// Scoreboard bench for laser_pulse_monitor: a run-length reference model
// predicts pulse results, a negedge monitor compares them.
module tb_laser_pulse_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       x_drv;
    logic       b;
    logic       use_timer;
    logic [1:0] tcnt = 2'd0;
    logic       x;

    logic       done;
    logic [3:0] pulse_len;
    logic       ok;
    logic       stuck;
    logic [7:0] good_cnt;
    logic [7:0] bad_cnt;

    typedef struct {
        int   len;
        logic ok;
        int   good;
        int   bad;
    } exp_t;

    exp_t q[$];
    int   run;
    int   m_good;
    int   m_bad;
    logic m_stuck;
    int   m_len;
    logic m_ok;

    int checks = 0;
    int passed = 0;

    laser_pulse_monitor #(
        .PULSE_CYCLES (3),
        .MAX_LEN      (15),
        .CNT_W        (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .done      (done),
        .pulse_len (pulse_len),
        .ok        (ok),
        .stuck     (stuck),
        .good_cnt  (good_cnt),
        .bad_cnt   (bad_cnt)
    );

    always #5 clk = ~clk;

    // Mealy laser timer: one-cycle trigger b yields a three-cycle enable.
    always @(posedge clk) begin
        if (b) tcnt <= 2'd2;
        else if (tcnt != 2'd0) tcnt <= tcnt - 2'd1;
    end
    assign x = use_timer ? (b || (tcnt != 2'd0)) : x_drv;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        run     = 0;
        m_good  = 0;
        m_bad   = 0;
        m_stuck = 1'b0;
        m_len   = 0;
        m_ok    = 1'b0;
        q.delete();
    endtask

    // Reference model: rules stated over the length of each high run of x.
    always @(posedge clk) begin
        if (!rst) begin
            if (x) begin
                run++;
                if (run == 15) m_bad++;
                m_stuck = (run >= 15);
            end else begin
                if (run >= 1 && run < 15) begin
                    if (run == 3) m_good++;
                    else m_bad++;
                    m_len = run;
                    m_ok  = (run == 3);
                    q.push_back('{run, (run == 3), m_good, m_bad});
                end
                run     = 0;
                m_stuck = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (q.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                e = q.pop_front();
                chk("done_pulse_len", pulse_len, e.len);
                chk("done_ok", ok, e.ok);
                chk("done_good_cnt", good_cnt, e.good % 256);
                chk("done_bad_cnt", bad_cnt, e.bad % 256);
            end
        end else if (q.size() != 0) begin
            e = q.pop_front();
            chk("missing_done", 0, 1);
        end
        chk("stuck", stuck, m_stuck);
        chk("pulse_len_hold", pulse_len, m_len);
        chk("ok_hold", ok, m_ok);
        chk("good_cnt", good_cnt, m_good % 256);
        chk("bad_cnt", bad_cnt, m_bad % 256);
    end

    task automatic step(input logic v);
        x_drv = v;
        @(posedge clk);
        #2;
    endtask

    task automatic pulse(input int hi, input int lo);
        repeat (hi) step(1'b1);
        repeat (lo) step(1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pulse_len"}, pulse_len, 0);
        chk({tag, "_ok"}, ok, 0);
        chk({tag, "_stuck"}, stuck, 0);
        chk({tag, "_good"}, good_cnt, 0);
        chk({tag, "_bad"}, bad_cnt, 0);
    endtask

    task automatic do_reset();
        x_drv = 1'b0;
        rst   = 1'b1;
        model_reset();
        #1;
        chk_all_zero("reset");
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        x_drv     = 1'b0;
        b         = 1'b0;
        use_timer = 1'b0;
        model_reset();
        #1;
        chk_all_zero("por");
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        // Nominal 3-cycle pulse
        pulse(3, 2);
        chk("nominal_len", pulse_len, 3);
        chk("nominal_ok", ok, 1);
        chk("nominal_good", good_cnt, 1);
        chk("nominal_bad", bad_cnt, 0);

        // Back-to-back short and long pulses
        do_reset();
        pulse(2, 1);
        pulse(4, 2);
        chk("b2b_len", pulse_len, 4);
        chk("b2b_good", good_cnt, 0);
        chk("b2b_bad", bad_cnt, 2);

        // Stuck-high
        do_reset();
        repeat (20) step(1'b1);
        chk("stuck_set", stuck, 1);
        chk("stuck_bad", bad_cnt, 1);
        step(1'b0);
        chk("stuck_clear", stuck, 0);
        chk("stuck_no_len", pulse_len, 0);
        step(1'b0);

        // Width boundary around MAX_LEN
        do_reset();
        pulse(14, 1);
        chk("max_len_pulse", pulse_len, 14);
        pulse(15, 1);
        chk("at_max_len_bad", bad_cnt, 2);
        chk("at_max_len_keep", pulse_len, 14);

        // Reset held through the rest of a pulse discards it
        do_reset();
        step(1'b1);
        x_drv = 1'b1;
        rst   = 1'b1;
        model_reset();
        #1;
        chk_all_zero("midrst");
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (3) step(1'b0);
        chk("midrst_good", good_cnt, 0);
        chk("midrst_bad", bad_cnt, 0);

        // Reset released with x high restarts from len=1
        step(1'b1);
        x_drv = 1'b1;
        rst   = 1'b1;
        model_reset();
        @(posedge clk); #2;
        rst = 1'b0;
        pulse(3, 2);
        chk("restart_len", pulse_len, 3);
        chk("restart_good", good_cnt, 1);

        // Counter wrap
        do_reset();
        repeat (256) pulse(3, 1);
        chk("wrap_good", good_cnt, 0);
        pulse(3, 1);
        chk("wrap_plus1", good_cnt, 1);

        // Driven by the laser timer
        do_reset();
        use_timer = 1'b1;
        b = 1'b1;
        @(posedge clk); #2;
        b = 1'b0;
        repeat (5) begin
            @(posedge clk); #2;
        end
        chk("timer_len", pulse_len, 3);
        chk("timer_ok", ok, 1);
        chk("timer_good", good_cnt, 1);
        use_timer = 1'b0;

        // Random pulse trains
        do_reset();
        repeat (400) pulse(int'($urandom_range(1, 18)), int'($urandom_range(1, 3)));
        repeat (3) step(1'b0);
        chk("queue_drained", q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
